// File: rtl/video_mode_probe_if.sv
// rtl/video_mode_probe_if.sv - video timing inputs and measured mode outputs of the probe
interface video_mode_probe_if;
    logic        ce_pix;
    logic        hs;
    logic        vs;
    logic        de;
    logic [11:0] h_total;
    logic [11:0] h_active;
    logic [11:0] v_total;
    logic [11:0] v_active;
    logic        hs_pol;
    logic        vs_pol;
    logic        valid;
    logic        mode_change;

    modport master (
        output ce_pix, hs, vs, de,
        input  h_total, h_active, v_total, v_active, hs_pol, vs_pol, valid, mode_change
    );

    modport slave (
        input  ce_pix, hs, vs, de,
        output h_total, h_active, v_total, v_active, hs_pol, vs_pol, valid, mode_change
    );
endinterface

// File: rtl/video_mode_probe.sv
// rtl/video_mode_probe.sv - measures video line/frame timing and reports a mode once stable
module video_mode_probe #(
    parameter int STABLE_FRAMES = 3,
    parameter int TIMEOUT_CLKS  = 2000000
) (
    input  logic                clk,
    input  logic                reset_n,
    video_mode_probe_if.slave   vif
);
    localparam int TW = $clog2(TIMEOUT_CLKS + 1);

    typedef enum logic [1:0] {SYNC_WAIT, ACQUIRE, LOCKED} state_t;

    function automatic logic [11:0] sat_inc(input logic [11:0] x);
        return (x == 12'hFFF) ? x : x + 12'd1;
    endfunction

    state_t      state_q, state_d;
    logic        hs_r_q, vs_r_q, hs_p_q, vs_p_q;
    logic        hs_r_d, vs_r_d, hs_p_d, vs_p_d;
    logic [11:0] hcnt_q, dcnt_q, line_tot_q, max_act_q, vcnt_q, vact_q;
    logic [11:0] hcnt_d, dcnt_d, line_tot_d, max_act_d, vcnt_d, vact_d;
    logic [49:0] ref_q, ref_d, out_q, out_d;
    logic        ref_ok_q, ref_ok_d;
    logic [3:0]  match_q, match_d;
    logic        valid_q, valid_d, mc_q, mc_d;
    logic [TW-1:0] tmo_q, tmo_d;

    logic        hs_edge, vs_edge, timeout_hit;
    logic [11:0] m_line_tot, m_max, m_vcnt, m_vact;
    logic [49:0] frame_m;

    // Edges are judged on syncs normalised by the current polarity estimate.
    assign hs_edge = vif.ce_pix & (vif.hs ^ ~hs_p_q) & ~(hs_r_q ^ ~hs_p_q);
    assign vs_edge = vif.ce_pix & (vif.vs ^ ~vs_p_q) & ~(vs_r_q ^ ~vs_p_q);

    // Frame tuple already includes a coincident HS update.
    assign m_line_tot = hs_edge ? sat_inc(hcnt_q) : line_tot_q;
    assign m_max      = (hs_edge && dcnt_q > max_act_q) ? dcnt_q : max_act_q;
    assign m_vcnt     = hs_edge ? sat_inc(vcnt_q) : vcnt_q;
    assign m_vact     = (hs_edge && dcnt_q != 12'd0) ? sat_inc(vact_q) : vact_q;
    assign frame_m    = {m_line_tot, m_max, m_vcnt, m_vact, hs_p_q, vs_p_q};

    assign timeout_hit = !vs_edge && (tmo_q == TW'(TIMEOUT_CLKS - 1));

    always_comb begin
        hs_r_d     = hs_r_q;
        vs_r_d     = vs_r_q;
        hs_p_d     = hs_p_q;
        vs_p_d     = vs_p_q;
        hcnt_d     = hcnt_q;
        dcnt_d     = dcnt_q;
        line_tot_d = m_line_tot;
        max_act_d  = vs_edge ? 12'd0 : m_max;
        vcnt_d     = vs_edge ? 12'd0 : m_vcnt;
        vact_d     = vs_edge ? 12'd0 : m_vact;
        if (vif.ce_pix) begin
            hs_r_d = vif.hs;
            vs_r_d = vif.vs;
            if (vif.de) begin
                hs_p_d = ~vif.hs;
                vs_p_d = ~vif.vs;
            end
            if (hs_edge) begin
                hcnt_d = 12'd0;
                dcnt_d = {11'd0, vif.de};
            end else begin
                hcnt_d = sat_inc(hcnt_q);
                if (vif.de) dcnt_d = sat_inc(dcnt_q);
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        ref_d    = ref_q;
        ref_ok_d = ref_ok_q;
        match_d  = match_q;
        valid_d  = valid_q;
        mc_d     = 1'b0;
        out_d    = out_q;
        tmo_d    = (vs_edge || timeout_hit) ? '0 : tmo_q + TW'(1);
        if (timeout_hit) begin
            state_d = SYNC_WAIT;
            valid_d = 1'b0;
        end else if (vs_edge) begin
            case (state_q)
                SYNC_WAIT: begin
                    state_d  = ACQUIRE;
                    match_d  = 4'd0;
                    ref_ok_d = 1'b0;
                end
                ACQUIRE: begin
                    if (ref_ok_q && frame_m == ref_q) begin
                        match_d = match_q + 4'd1;
                    end else begin
                        ref_d    = frame_m;
                        ref_ok_d = 1'b1;
                        match_d  = 4'd1;
                    end
                    if (match_d == 4'(STABLE_FRAMES)) begin
                        out_d   = frame_m;
                        valid_d = 1'b1;
                        mc_d    = 1'b1;
                        state_d = LOCKED;
                    end
                end
                LOCKED: begin
                    if (frame_m != ref_q) begin
                        valid_d = 1'b0;
                        ref_d   = frame_m;
                        match_d = 4'd1;
                        state_d = ACQUIRE;
                    end
                end
                default: state_d = SYNC_WAIT;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= SYNC_WAIT;
            hs_r_q     <= 1'b0;
            vs_r_q     <= 1'b0;
            hs_p_q     <= 1'b0;
            vs_p_q     <= 1'b0;
            hcnt_q     <= '0;
            dcnt_q     <= '0;
            line_tot_q <= '0;
            max_act_q  <= '0;
            vcnt_q     <= '0;
            vact_q     <= '0;
            ref_q      <= '0;
            ref_ok_q   <= 1'b0;
            match_q    <= '0;
            out_q      <= '0;
            valid_q    <= 1'b0;
            mc_q       <= 1'b0;
            tmo_q      <= '0;
        end else begin
            state_q    <= state_d;
            hs_r_q     <= hs_r_d;
            vs_r_q     <= vs_r_d;
            hs_p_q     <= hs_p_d;
            vs_p_q     <= vs_p_d;
            hcnt_q     <= hcnt_d;
            dcnt_q     <= dcnt_d;
            line_tot_q <= line_tot_d;
            max_act_q  <= max_act_d;
            vcnt_q     <= vcnt_d;
            vact_q     <= vact_d;
            ref_q      <= ref_d;
            ref_ok_q   <= ref_ok_d;
            match_q    <= match_d;
            out_q      <= out_d;
            valid_q    <= valid_d;
            mc_q       <= mc_d;
            tmo_q      <= tmo_d;
        end
    end

    assign vif.h_total     = out_q[49:38];
    assign vif.h_active    = out_q[37:26];
    assign vif.v_total     = out_q[25:14];
    assign vif.v_active    = out_q[13:2];
    assign vif.hs_pol      = out_q[1];
    assign vif.vs_pol      = out_q[0];
    assign vif.valid       = valid_q;
    assign vif.mode_change = mc_q;
endmodule

// File: tb/tb_video_mode_probe.sv
// tb/tb_video_mode_probe.sv - directed checks of mode locking, re-lock, timeout and reset
module tb_video_mode_probe;
    localparam int H  = 20;
    localparam int V  = 12;
    localparam int VP = 14;

    logic clk;
    logic reset_n;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   mc_cnt = 0, bad_mc = 0, valid_cycles = 0;
    int   mc_base, vc_base;

    video_mode_probe_if vif();

    video_mode_probe #(.STABLE_FRAMES(3), .TIMEOUT_CLKS(1500)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .vif     (vif)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(negedge clk) begin
        if (vif.mode_change) mc_cnt++;
        if (vif.mode_change && !vif.valid) bad_mc++;
        if (vif.valid) valid_cycles++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_mode(input string tag, input int ht, input int ha, input int vt,
                              input int va, input int hp, input int vp, input int vld);
        check({tag, ".h_total"},  32'(vif.h_total),  ht);
        check({tag, ".h_active"}, 32'(vif.h_active), ha);
        check({tag, ".v_total"},  32'(vif.v_total),  vt);
        check({tag, ".v_active"}, 32'(vif.v_active), va);
        check({tag, ".hs_pol"},   32'(vif.hs_pol),   hp);
        check({tag, ".vs_pol"},   32'(vif.vs_pol),   vp);
        check({tag, ".valid"},    32'(vif.valid),    vld);
    endtask

    task automatic pix(input logic h, input logic v, input logic d);
        vif.ce_pix = 1'b1;
        vif.hs = h;
        vif.vs = v;
        vif.de = d;
        @(posedge clk); #1;
        vif.ce_pix = 1'b0;
        @(posedge clk); #1;
    endtask

    // 20-pixel lines: HS x<2, DE x=4..17; VS on lines 0..1, DE on lines 3..10.
    task automatic send_frame(input int vlines, input int y0, input int x0, input int y1,
                              input bit inv, input bit kill_vs);
        for (int y = y0; y < y1 && y < vlines; y++) begin
            for (int x = (y == y0) ? x0 : 0; x < H; x++) begin
                logic ah, av, d;
                ah = (x < 2);
                av = (y < 2) && !kill_vs;
                d  = (x >= 4) && (x < 18) && (y >= 3) && (y < 11);
                pix(inv ? ah : ~ah, inv ? av : ~av, d);
            end
        end
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    initial begin
        reset_n    = 1'b0;
        vif.ce_pix = 1'b0;
        vif.hs     = 1'b1;
        vif.vs     = 1'b1;
        vif.de     = 1'b0;
        do_reset();
        check_mode("reset", 0, 0, 0, 0, 0, 0, 0);
        check("reset.mode_change", 32'(vif.mode_change), 0);

        // Partial frame, three full frames, then the closing VS sample locks.
        mc_base = mc_cnt;
        send_frame(V, 5, 0, V, 1'b0, 1'b0);
        for (int f = 0; f < 3; f++) send_frame(V, 0, 0, V, 1'b0, 1'b0);
        check("pre_lock.valid", 32'(vif.valid), 0);
        vif.ce_pix = 1'b1; vif.hs = 1'b0; vif.vs = 1'b0; vif.de = 1'b0;
        @(posedge clk); #1;
        vif.ce_pix = 1'b0;
        check_mode("lock", H, 14, V, 8, 0, 0, 1);
        check("lock.mode_change", 32'(vif.mode_change), 1);
        @(posedge clk); #1;
        check("lock.mc_one_clk", 32'(vif.mode_change), 0);
        send_frame(V, 0, 1, V, 1'b0, 1'b0);
        check("lock.mc_count", 32'(mc_cnt - mc_base), 1);

        // Switch to 14-line frames: drop after first one, re-lock two frames later.
        mc_base = mc_cnt;
        send_frame(VP, 0, 0, VP, 1'b0, 1'b0);
        send_frame(VP, 0, 0, VP, 1'b0, 1'b0);
        check_mode("pal_drop", H, 14, V, 8, 0, 0, 0);
        send_frame(VP, 0, 0, VP, 1'b0, 1'b0);
        check("pal_wait.valid", 32'(vif.valid), 0);
        send_frame(VP, 0, 0, VP, 1'b0, 1'b0);
        check_mode("pal_lock", H, 14, VP, 8, 0, 0, 1);
        check("pal.mc_count", 32'(mc_cnt - mc_base), 1);

        // VS held inactive past the timeout, then restored.
        mc_base = mc_cnt;
        for (int f = 0; f < 4; f++) send_frame(VP, 0, 0, VP, 1'b0, 1'b1);
        check_mode("timeout", H, 14, VP, 8, 0, 0, 0);
        for (int f = 0; f < 3; f++) send_frame(VP, 0, 0, VP, 1'b0, 1'b0);
        check("relock_wait.valid", 32'(vif.valid), 0);
        send_frame(VP, 0, 0, VP, 1'b0, 1'b0);
        check_mode("relock", H, 14, VP, 8, 0, 0, 1);
        check("relock.mc_count", 32'(mc_cnt - mc_base), 1);

        // Asynchronous reset in the middle of a frame.
        send_frame(VP, 0, 0, 7, 1'b0, 1'b0);
        reset_n = 1'b0;
        #2;
        check_mode("mid_reset", 0, 0, 0, 0, 0, 0, 0);
        check("mid_reset.mode_change", 32'(vif.mode_change), 0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        mc_base = mc_cnt;
        send_frame(V, 7, 0, V, 1'b0, 1'b0);
        for (int f = 0; f < 3; f++) send_frame(V, 0, 0, V, 1'b0, 1'b0);
        check("post_reset_wait.valid", 32'(vif.valid), 0);
        send_frame(V, 0, 0, V, 1'b0, 1'b0);
        check_mode("post_reset_lock", H, 14, V, 8, 0, 0, 1);
        check("post_reset.mc_count", 32'(mc_cnt - mc_base), 1);

        // Inverted syncs: polarity is learned during DE.
        do_reset();
        mc_base = mc_cnt;
        send_frame(V, 5, 0, V, 1'b1, 1'b0);
        for (int f = 0; f < 7; f++) send_frame(V, 0, 0, V, 1'b1, 1'b0);
        check_mode("inverted", H, 14, V, 8, 1, 1, 1);
        check("inverted.mc_count", 32'(mc_cnt - mc_base), 1);

        // Alternating 12/13-line frames never settle.
        do_reset();
        mc_base = mc_cnt;
        vc_base = valid_cycles;
        send_frame(V, 5, 0, V, 1'b0, 1'b0);
        for (int f = 0; f < 10; f++) send_frame((f % 2 == 0) ? V : V + 1, 0, 0, V + 1, 1'b0, 1'b0);
        check("alternating.valid_cycles", 32'(valid_cycles - vc_base), 0);
        check("alternating.mc_count", 32'(mc_cnt - mc_base), 0);
        check_mode("alternating", 0, 0, 0, 0, 0, 0, 0);

        check("mc_without_valid", 32'(bad_mc), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/video_mode_probe.md
Name: video_mode_probe

Overview:
- Sink-side monitor for the core video interface: pixel enable, HSync, VSync and DE, all driven on the system clock.
- Measures the raw timing and reports total and active line and pixel counts plus sync polarities.
- Reports a mode only after it has stayed identical for a set number of frames.
- Feeds OSD info and mode-change handling, and lets benches check the video generators.

Parameters:
- STABLE_FRAMES, 3: number of consecutive identical frames required before valid asserts (range 2..15).
- TIMEOUT_CLKS, 2000000: clk cycles without an active VSync leading edge before the signal is declared lost.

Ports:
- clk  in  1  system clock; all inputs are synchronous to it.
- reset_n  in  1  asynchronous active-low reset.
- ce_pix  in  1  pixel enable; inputs are sampled only when this is 1.
- hs  in  1  horizontal sync, either polarity.
- vs  in  1  vertical sync, either polarity.
- de  in  1  display enable, equal to ~(HBlank|VBlank).
- h_total  out  12  ce_pix ticks per line.
- h_active  out  12  DE ticks per line.
- v_total  out  12  lines per frame.
- v_active  out  12  lines containing DE.
- hs_pol  out  1  1 = active-high HSync.
- vs_pol  out  1  1 = active-high VSync.
- valid  out  1  reported mode is locked.
- mode_change  out  1  one-clk pulse when a new mode is locked.

Behaviour:
- Reset: all outputs are 0, state is SYNC_WAIT, all counters and the reference tuple are cleared. Reset takes effect immediately when asserted, including mid-frame.
- Sampling and polarity:
  - Registers hs_r, vs_r and de_r update only on ce_pix. All edges are evaluated on sampled values.
  - The polarity estimate is taken on every ce_pix with de=1: hs_p = ~hs, vs_p = ~vs.
  - Normalised syncs: hs_a = hs ^ ~hs_p, vs_a = vs ^ ~vs_p.
  - An active leading edge is hs_a (or vs_a) going 0 to 1 between consecutive samples.
- Horizontal counting:
  - hcnt increments on each ce_pix and saturates at 4095.
  - dcnt increments on ce_pix&de and saturates at 4095.
  - On an HS leading edge, line_tot = hcnt+1 and line_act = dcnt are latched, then both counters restart (hcnt from 0, dcnt from de of the current sample).
- Line and frame counting:
  - On each HS edge, vcnt increments (saturating at 4095).
  - vact increments if the completed line had dcnt ≠ 0.
  - On a VS leading edge, frame tuple M = {line_tot, max line_act seen this frame, vcnt, vact, hs_p, vs_p} is formed, and vcnt and vact restart at 0.
  - If HS and VS edges occur in the same sample, the HS update is applied first, then the frame closes.
- State machine:
  - SYNC_WAIT: the first VS edge discards M as a partial frame → ACQUIRE, with match = 0 and ref = invalid.
  - ACQUIRE, on each VS edge:
    - If M == ref: match++.
    - Otherwise: ref = M, match = 1.
    - When match reaches STABLE_FRAMES: drive outputs from ref, set valid = 1, pulse mode_change for exactly 1 clk, → LOCKED.
  - LOCKED, on each VS edge:
    - If M == ref: no output change.
    - Otherwise: valid = 0 on the next clk, ref = M, match = 1, → ACQUIRE. The measurement outputs hold their last locked values.
  - Any state: a timeout counter (clk-based, reset on every VS edge) reaching TIMEOUT_CLKS → valid = 0 and → SYNC_WAIT. The measurement outputs hold their values.
- Output timing: valid and mode_change change exactly 1 clk after the clk on which the closing VS edge is sampled.
- mode_change never pulses without valid rising in the same cycle. A re-lock to the same tuple after loss still pulses.
- Saturated counts (4095) are still compared normally; a frame whose counts saturate consistently can lock.

Test Plan:
- 400x262 line/frame timing with 320x240 active, active-low HS/VS, ce_pix every 4 clk, STABLE_FRAMES=3 → after the partial frame plus 3 full frames: valid=1, h_total=400, h_active=320, v_total=262, v_active=240, hs_pol=0, vs_pol=0, with one mode_change pulse.
- Same timing with both syncs inverted → lock with identical counts, hs_pol=1, vs_pol=1.
- Locked, then switch to PAL timing (v_total=312) → valid drops 1 clk after the first 312-line frame and re-locks 2 frames later with v_total=312; mode_change pulses once.
- Locked, then hold vs inactive for TIMEOUT_CLKS → valid=0, old counts retained; restoring vs → re-lock and mode_change after 1+STABLE_FRAMES frames.
- reset_n pulsed low mid-frame → all outputs 0 immediately; lock requires a fresh partial frame plus STABLE_FRAMES frames.
- Alternating 262/263-line frames → never locks, valid stays 0, no mode_change.
